// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word width, opcode constants and the
// fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction until decode takes it.
// Flush beats load, and load beats the consume-clear.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign id_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, redirect
// with kill of an in-flight response, and an IF/ID output register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic [0:0]  dbg_fetch_state
);

  // Handshake rule for both imem and decode ports: a transfer happens on a
  // rising edge where valid && ready; valid never depends on ready except the
  // request side, which may only fetch when the IF/ID slot will be free.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  logic         req_fire;
  logic         rsp_load;

  assign imem_req_valid = rst_n && (state_q == FETCH_REQ) && (!id_valid || id_ready)
                          && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_load       = (state_q == FETCH_WAIT) && imem_rsp_valid && !kill_q
                          && !redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_target);
      if (state_q == FETCH_WAIT) begin
        if (imem_rsp_valid) begin
          state_d = FETCH_REQ;
          kill_d  = 1'b0;
        end else begin
          kill_d  = 1'b1;
        end
      end
    end else if (state_q == FETCH_REQ) begin
      if (req_fire) begin
        state_d  = FETCH_WAIT;
        req_pc_d = pc_q;
      end
    end else if (imem_rsp_valid) begin
      // A killed response leaves pc at the redirect target.
      state_d = FETCH_REQ;
      kill_d  = 1'b0;
      if (!kill_q) pc_d = req_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (rsp_load),
    .load_pc    (req_pc_q),
    .load_instr (imem_rsp_data),
    .flush      (redirect_valid),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr)
  );

  assign id_opcode       = id_instr[6:0];
  assign dbg_fetch_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, with a
// program-order reference model and a monitor checking every decoded word.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_opcode;
  logic [0:0]  dbg_fetch_state;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .id_opcode(id_opcode),
    .dbg_fetch_state(dbg_fetch_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_cons   = 0;

  // Reference model: next PC decode must see in program order.
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          cons_cyc_q[$];

  // Memory model state: a single pending response with a cycle countdown.
  bit          rsp_pending = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_word = '0;
  int          dly = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit idr, input bit redir, input logic [31:0] tgt,
                       input bit mrdy, input bit rel);
    @(negedge clk);
    cyc++;
    if (rel) rst_n = 1'b1;
    id_ready        = redir ? 1'b0 : idr;
    redirect_valid  = redir;
    redirect_target = tgt;
    imem_req_ready  = mrdy;
    if (rsp_pending && rsp_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = rsp_word;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (imem_rsp_valid) rsp_pending = 0;
    else if (rsp_pending) rsp_cnt--;
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", {31'b0, rsp_pending}, 32'd0);
      chk("req_addr_aligned", {30'b0, imem_req_addr[1:0]}, 32'd0);
      rsp_pending = 1;
      rsp_cnt     = dly - 1;
      rsp_word    = mem_word(imem_req_addr);
      acc_cyc_q.push_back(cyc);
    end
    if (redir) begin
      exp_q.delete();
      exp_q.push_back({tgt[31:2], 2'b00});
    end
  endtask

  // Monitor: checks every instruction decode consumes against the model.
  always @(negedge clk) begin
    logic [31:0] e, w;
    #2;
    if (rst_n) begin
      if (id_valid && !id_ready)
        chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
      if (id_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 32'd0, 32'd1);
          e = id_pc;
        end else begin
          e = exp_q.pop_front();
        end
        w = mem_word(e);
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, w);
        chk("id_opcode", {25'b0, id_opcode}, {25'b0, w[6:0]});
        exp_q.push_back(e + 32'd4);
        cons_cyc_q.push_back(cyc);
        n_cons++;
      end
    end
  end

  initial begin
    logic [31:0] held_pc, held_instr;
    bool_loop: begin end
    exp_q.push_back(RESET_PC);

    // Reset held: outputs quiet and cleared.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    end
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);

    // Best-case streaming.
    dly = 1;
    cycle(1, 0, 0, 1, 1);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    cycle(1, 0, 0, 1, 0);
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    cycle(1, 0, 0, 1, 0);
    chk("req2_addr", imem_req_addr, 32'h4);
    chk("id0_valid", {31'b0, id_valid}, 32'd1);
    cycle(1, 0, 0, 1, 0);
    dly = 3;
    cycle(1, 0, 0, 1, 0);
    chk("req3_addr", imem_req_addr, 32'h8);

    // Redirect while waiting on 0x8: response killed.
    cycle(1, 1, 32'h100, 1, 0);
    chk("rd_id_valid", {31'b0, id_valid}, 32'd0);
    chk("acc_spacing", acc_cyc_q[1] - acc_cyc_q[0], 32'd2);
    chk("cons_spacing", cons_cyc_q[1] - cons_cyc_q[0], 32'd2);
    chk("accept_to_id_latency", cons_cyc_q[0] - acc_cyc_q[0], 32'd2);
    cycle(1, 0, 0, 1, 0);
    chk("kill_wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    cycle(1, 0, 0, 1, 0);
    chk("kill_rsp_no_req", {31'b0, imem_req_valid}, 32'd0);
    dly = 2;
    cycle(1, 0, 0, 1, 0);
    chk("kill_dropped", {31'b0, id_valid}, 32'd0);
    chk("redir_req_addr", imem_req_addr, 32'h100);

    // Redirect coincident with response: dropped, target aligned.
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 32'h203, 1, 0);
    cycle(1, 0, 0, 0, 0);
    chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    chk("coinc_id_valid", {31'b0, id_valid}, 32'd0);

    // PC wrap at the top of the address space.
    cycle(1, 1, 32'hFFFF_FFFC, 0, 0);
    dly = 1;
    cycle(1, 0, 0, 1, 0);
    chk("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 1, 0);
    dly = 4;
    cycle(1, 0, 0, 1, 0);
    chk("top_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_req_addr", imem_req_addr, 32'h0);

    // Mid-operation asynchronous reset while a response is outstanding.
    cycle(1, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    #1;
    chk("async_rst_id_pc", id_pc, 32'd0);
    chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_req_addr", imem_req_addr, RESET_PC);
    cycle(1, 0, 0, 0, 0);
    dly = 1;
    cycle(1, 0, 0, 1, 0);
    chk("stale_rsp_ignored", {31'b0, id_valid}, 32'd0);
    chk("stale_req_addr", imem_req_addr, RESET_PC);

    // Decode stall for five cycles.
    for (int i = 0; i < 10 && !id_valid; i++) cycle(0, 0, 0, 1, 0);
    chk("stall_id_valid", {31'b0, id_valid}, 32'd1);
    held_pc    = id_pc;
    held_instr = id_instr;
    chk("stall_held_pc", held_pc, RESET_PC);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("stall_pc_stable", id_pc, RESET_PC);
      chk("stall_instr_stable", id_instr, mem_word(RESET_PC));
      chk("stall_req_low", {31'b0, imem_req_valid}, 32'd0);
    end
    cycle(1, 0, 0, 1, 0);
    chk("unstall_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("unstall_req_addr", imem_req_addr, RESET_PC + 32'd4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      bit redir;
      dly   = $urandom_range(1, 3);
      redir = ($urandom_range(0, 29) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      cycle($urandom_range(0, 9) < 7, redir, tgt, $urandom_range(0, 9) < 7, 0);
    end
    repeat (2) @(negedge clk);
    chk("progress", {31'b0, n_cons >= 200}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL indicate a fetch request is presented.
REQ-005 imem_req_ready  input  1  SHALL indicate instruction memory accepts the request this cycle.
REQ-006 imem_req_addr  output  32  SHALL carry the fetch address (current PC).
REQ-007 imem_rsp_valid  input  1  SHALL indicate imem_rsp_data is valid; earliest one cycle after acceptance.
REQ-008 imem_rsp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect_valid  input  1  SHALL be a one-cycle pulse requesting a PC change (taken branch, target = PC + ImmExt from downstream).
REQ-010 redirect_target  input  32  SHALL carry the new PC.
REQ-011 id_valid  output  1  SHALL indicate id_pc/id_instr hold a valid fetched instruction.
REQ-012 id_ready  input  1  SHALL indicate the decode stage consumes the instruction this cycle.
REQ-013 id_pc  output  32  SHALL carry the PC of id_instr.
REQ-014 id_instr  output  32  SHALL carry the instruction word; drives the immediate generator instruction input.
REQ-015 id_opcode  output  7  SHALL equal id_instr[6:0] combinationally; drives the immediate generator opcode input.

Function
REQ-016 FSM SHALL have two states: REQ (request pending) and WAIT (one request outstanding); at most one request outstanding.
REQ-017 In REQ, imem_req_valid SHALL be 1 only when (!id_valid || id_ready) and !redirect_valid; imem_req_addr = pc.
REQ-018 Request accepted (imem_req_valid && imem_req_ready) SHALL move REQ->WAIT and latch req_pc = pc.
REQ-019 In WAIT with imem_rsp_valid and kill=0, next edge SHALL set id_valid=1, id_pc=req_pc, id_instr=imem_rsp_data, pc=req_pc+4, state REQ.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 id_valid SHALL clear on id_valid && id_ready unless a new instruction loads that edge.
REQ-022 imem_rsp_valid SHALL be ignored in REQ.
REQ-023 redirect_valid SHALL have highest priority: next edge pc={redirect_target[31:2],2'b00}, id_valid=0.
REQ-024 Redirect in WAIT SHALL set kill=1; the next response SHALL be discarded, then kill=0, state REQ, pc unchanged.
REQ-025 Redirect coincident with imem_rsp_valid in WAIT SHALL discard that response, state REQ, kill=0.
REQ-026 Redirect in WAIT with kill already 1 SHALL only update pc; kill stays 1.
REQ-027 Best-case throughput (ready memory, 1-cycle response, id_ready=1): one instruction per 2 cycles; request-accept to id_valid latency = 2 edges.

Reset
REQ-028 On rst_n=0, immediately: pc=RESET_PC, state REQ, kill=0, id_valid=0, id_pc=0, id_instr=0, req_pc=0.
REQ-029 During reset imem_req_valid SHALL be 0; first request SHALL present RESET_PC in the first cycle after rst_n rises.
REQ-030 A response for a request issued before a mid-operation reset SHALL be ignored (state REQ).

Structure
REQ-031 Package riscv_pkg SHALL hold XLEN=32, opcode constants OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100011, and the fetch state enum.
REQ-032 One sub-module if_id_reg SHALL implement the valid/ready output register (id_valid, id_pc, id_instr, flush input).

Verification
REQ-033 Reset release, RESET_PC=0, ready memory, 1-cycle rsp, id_ready=1 -> requests at 0x0,0x4,0x8; id_pc sequence 0x0,0x4,0x8 every 2 cycles.
REQ-034 id_ready=0 for 5 cycles with id_valid=1 -> id_pc/id_instr stable, imem_req_valid=0; id_ready=1 -> next request issued following cycle.
REQ-035 Redirect to 0x100 while WAIT on 0x8 -> 0x8 response discarded, id_valid stays 0, next request addr 0x100.
REQ-036 Redirect to 0x203 coincident with response -> response dropped, next addr 0x200.
REQ-037 pc=0xFFFF_FFFC fetched -> next request addr 0x0000_0000.
REQ-038 rst_n pulsed low in WAIT, rsp arrives after release -> ignored, first request addr RESET_PC, id_valid=0.
